// File: rtl/char_scan_ctrl.sv
// char_scan_ctrl: row-scan and scroll sequencer for an 8x8 LED character.
// Each row costs one FETCH cycle (row blanked while the ROM read is in flight)
// followed by ROW_HOLD DRIVE cycles. Glyph selection and scroll offset change
// only at frame boundaries, so a frame is never drawn with mixed settings.
module char_scan_ctrl #(
  parameter int ROW_HOLD   = 50000,  // drive cycles per row, >= 1
  parameter int SCROLL_DIV = 5000000 // scroll tick period in clk cycles, >= 2
) (
  input  logic       clk,
  input  logic       reset,          // synchronous, active-low
  input  logic       char_enable,
  input  logic [2:0] start_address,
  input  logic       S,
  input  logic       D,
  input  logic       U,
  output logic [5:0] rom_addr,
  input  logic [7:0] rom_data,
  output logic [7:0] row_sel,
  output logic [7:0] col_data,
  output logic       frame_start
);

  localparam int HOLD_W = (ROW_HOLD > 1) ? $clog2(ROW_HOLD) : 1;
  localparam int TICK_W = $clog2(SCROLL_DIV);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(ROW_HOLD - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SCROLL_DIV - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_DRIVE} state_t;
  typedef enum logic [1:0] {MODE_STOP, MODE_DOWN, MODE_UP} mode_t;

  state_t             state, next_state;
  mode_t              mode;
  logic [2:0]         glyph;
  logic [2:0]         offset;
  logic [2:0]         row;
  logic [2:0]         fetch_row;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [TICK_W-1:0]  tick_cnt;
  logic               tick_pending;
  logic               tick_wrap;
  logic [7:0]         col_q;
  logic               row_last;
  logic               drive_done;
  logic               frame_go;

  // Shared decodes: end of a row, and the frame-boundary transition into FETCH.
  assign fetch_row  = row + offset;
  assign tick_wrap  = (tick_cnt == TICK_LAST);
  assign row_last   = (hold_cnt == HOLD_LAST);
  assign drive_done = (state == ST_DRIVE) && row_last;
  assign frame_go   = char_enable &&
                      ((state == ST_IDLE) || (drive_done && (row == 3'd7)));

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state always uses non-blocking assignment so every
    // register samples the pre-edge values regardless of statement order.
    if (!reset) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default first, so no path through the case leaves next_state
    // unassigned and a latch is never inferred.
    next_state = state;
    unique case (state)
      ST_IDLE:  if (char_enable) next_state = ST_FETCH;
      ST_FETCH: next_state = ST_DRIVE;
      ST_DRIVE: begin
        if (row_last) begin
          if ((row == 3'd7) && !char_enable) next_state = ST_IDLE;
          else                               next_state = ST_FETCH;
        end
      end
      default:  next_state = ST_IDLE;
    endcase
  end

  // Datapath: scroll mode, tick generation, frame-boundary latching, row/hold counters.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mode         <= MODE_STOP;
      glyph        <= 3'd0;
      offset       <= 3'd0;
      row          <= 3'd0;
      hold_cnt     <= '0;
      tick_cnt     <= '0;
      tick_pending <= 1'b0;
      col_q        <= 8'd0;
    end else begin
      if (S)      mode <= MODE_STOP;
      else if (D) mode <= MODE_DOWN;
      else if (U) mode <= MODE_UP;

      tick_cnt <= tick_wrap ? '0 : tick_cnt + 1'b1;

      // A tick on the boundary edge itself survives the clear and is used next frame.
      tick_pending <= tick_wrap | (tick_pending & ~frame_go);

      if (frame_go) begin
        glyph <= start_address;
        if (start_address != glyph) begin
          offset <= 3'd0;
        end else if (tick_pending) begin
          if (mode == MODE_DOWN)    offset <= offset + 3'd1;
          else if (mode == MODE_UP) offset <= offset - 3'd1;
        end
      end

      // Row 7 + 1 wraps to 0, which is also where a new frame or IDLE must start.
      if (drive_done) row <= row + 3'd1;

      if (state == ST_DRIVE) hold_cnt <= row_last ? '0 : hold_cnt + 1'b1;
      else                   hold_cnt <= '0;

      // ROM data for this row is valid only on the first DRIVE cycle; keep it.
      if ((state == ST_DRIVE) && (hold_cnt == '0)) col_q <= rom_data;
    end
  end

  // Outputs decoded from state; FETCH keeps the row dark while the ROM responds.
  always_comb begin
    rom_addr    = 6'd0;
    row_sel     = 8'd0;
    col_data    = 8'd0;
    frame_start = 1'b0;
    unique case (state)
      ST_FETCH: begin
        rom_addr    = {glyph, fetch_row};
        frame_start = (row == 3'd0);
      end
      ST_DRIVE: begin
        rom_addr = {glyph, fetch_row};
        row_sel  = 8'd1 << row;
        col_data = (hold_cnt == '0) ? rom_data : col_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_char_scan_ctrl.sv
// Directed bench for char_scan_ctrl with ROW_HOLD=3 (row period 4, frame 32)
// and SCROLL_DIV=40. Expected frame addresses are worked out from those periods:
// with reset released at edge E0, ticks land on E40*m and frame k starts at
// edge E(2+32k), so frames with k mod 5 == 1 see no new tick.
module tb_char_scan_ctrl;

  localparam int ROW_HOLD   = 3;
  localparam int SCROLL_DIV = 40;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       char_enable = 1'b0;
  logic [2:0] start_address = 3'd0;
  logic       S = 1'b0;
  logic       D = 1'b0;
  logic       U = 1'b0;
  logic [5:0] rom_addr;
  logic [7:0] rom_data = 8'd0;
  logic [7:0] row_sel;
  logic [7:0] col_data;
  logic       frame_start;

  int checks = 0;
  int failures = 0;

  // Row-0 fetch addresses for frames k=2..10 with D held (glyph 2).
  logic [5:0] d_exp [9] = '{6'h11, 6'h12, 6'h13, 6'h14, 6'h14, 6'h15, 6'h16, 6'h17, 6'h10};

  char_scan_ctrl #(
    .ROW_HOLD  (ROW_HOLD),
    .SCROLL_DIV(SCROLL_DIV)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .char_enable  (char_enable),
    .start_address(start_address),
    .S            (S),
    .D            (D),
    .U            (U),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .row_sel      (row_sel),
    .col_data     (col_data),
    .frame_start  (frame_start)
  );

  always #5 clk = ~clk;

  // Synchronous character ROM with a distinct pattern at every address.
  function automatic logic [7:0] rom_fn(input logic [5:0] a);
    return {a, 2'b10} ^ 8'hA5;
  endfunction

  always @(posedge clk) rom_data <= rom_fn(rom_addr);

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next frame_start cycle, bounded to a little over one frame.
  task automatic wait_frame(input string tag);
    int n = 0;
    step(1);
    while (frame_start !== 1'b1 && n < 40) begin
      step(1);
      n++;
    end
    check(tag, {31'd0, frame_start}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fs_count;

    // Reset values.
    step(3);
    check("rst_row_sel", row_sel, 8'h00);
    check("rst_col_data", col_data, 8'h00);
    check("rst_rom_addr", rom_addr, 6'h00);
    check("rst_frame_start", frame_start, 1'b0);

    // Release (E0 is the last reset edge), then enable glyph 2.
    reset = 1'b1;
    step(1);
    char_enable   = 1'b1;
    start_address = 3'd2;
    step(1);

    // Frame 0: every row, STOP mode, offset 0.
    for (int r = 0; r < 8; r++) begin
      check($sformatf("f0_fetch_addr_r%0d", r), rom_addr, 32'h10 + r);
      check($sformatf("f0_fetch_blank_r%0d", r), row_sel, 8'h00);
      check($sformatf("f0_frame_start_r%0d", r), frame_start, (r == 0) ? 1'b1 : 1'b0);
      step(1);
      check($sformatf("f0_row_sel_r%0d", r), row_sel, 8'd1 << r);
      check($sformatf("f0_col_r%0d", r), col_data, rom_fn(6'h10 + 6'(r)));
      step(2);
      check($sformatf("f0_col_hold_r%0d", r), col_data, rom_fn(6'h10 + 6'(r)));
      step(1);
    end

    // Frame 1: boundary with no pending tick; hold D from here.
    check("f1_frame_start", frame_start, 1'b1);
    check("f1_addr", rom_addr, 6'h10);
    D = 1'b1;

    for (int k = 2; k <= 10; k++) begin
      wait_frame($sformatf("down_f%0d_reached", k));
      check($sformatf("down_f%0d_addr", k), rom_addr, d_exp[k-2]);
      if (k == 3) begin
        step(4);
        check("down_f3_row1_addr", rom_addr, 6'h13);
        step(1);
        check("down_f3_row1_sel", row_sel, 8'h02);
        check("down_f3_row1_col", col_data, rom_fn(6'h13));
      end
    end

    // Offset 0, switch to UP: k11 has no tick, k12 wraps to 7.
    D = 1'b0;
    U = 1'b1;
    wait_frame("up_f11_reached");
    check("up_f11_addr", rom_addr, 6'h10);
    wait_frame("up_f12_reached");
    check("up_f12_addr", rom_addr, 6'h17);

    // S wins over D and U: offset frozen across three ticks.
    S = 1'b1;
    D = 1'b1;
    for (int k = 13; k <= 15; k++) begin
      wait_frame($sformatf("stop_f%0d_reached", k));
      check($sformatf("stop_f%0d_addr", k), rom_addr, 6'h17);
    end

    // Glyph 1, scroll down to offset 5.
    start_address = 3'd1;
    S = 1'b0;
    U = 1'b0;
    wait_frame("g1_f16_reached");
    check("g1_f16_addr", rom_addr, 6'h08);
    for (int k = 17; k <= 22; k++) begin
      wait_frame($sformatf("g1_f%0d_reached", k));
    end
    check("g1_f22_addr", rom_addr, 6'h0D);

    // Mid-frame glyph change 1 -> 4 is ignored until the next boundary.
    step(6);
    start_address = 3'd4;
    S = 1'b1;
    step(2);
    check("g1_midframe_row2_addr", rom_addr, 6'h0F);
    step(1);
    check("g1_midframe_row2_sel", row_sel, 8'h04);
    check("g1_midframe_row2_col", col_data, rom_fn(6'h0F));
    wait_frame("g4_f23_reached");
    check("g4_f23_addr", rom_addr, 6'h20);
    wait_frame("g4_f24_reached");
    check("g4_f24_addr", rom_addr, 6'h20);

    // Glyph change on a tick frame clears the pending tick: k26 has no new tick.
    start_address = 3'd3;
    S = 1'b0;
    wait_frame("g3_f25_reached");
    check("g3_f25_addr", rom_addr, 6'h18);
    wait_frame("g3_f26_reached");
    check("g3_f26_addr", rom_addr, 6'h18);
    wait_frame("g3_f27_reached");
    check("g3_f27_addr", rom_addr, 6'h19);

    // char_enable dropped mid-frame: frame completes, then IDLE without a pulse.
    step(6);
    char_enable = 1'b0;
    step(23);
    check("drop_row7_sel", row_sel, 8'h80);
    check("drop_row7_col", col_data, rom_fn(6'h18));
    step(3);
    check("drop_idle_row_sel", row_sel, 8'h00);
    check("drop_idle_col", col_data, 8'h00);
    check("drop_idle_frame_start", frame_start, 1'b0);
    fs_count = 0;
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (frame_start === 1'b1) fs_count++;
    end
    check("drop_idle_no_pulse", fs_count, 0);
    check("drop_idle_row_sel_late", row_sel, 8'h00);

    // Re-enable with glyph 5, then reset during DRIVE of row 5.
    char_enable   = 1'b1;
    start_address = 3'd5;
    step(1);
    check("g5_frame_start", frame_start, 1'b1);
    check("g5_addr", rom_addr, 6'h28);
    step(22);
    check("g5_row5_sel", row_sel, 8'h20);
    check("g5_row5_col", col_data, rom_fn(6'h2D));
    reset = 1'b0;
    step(1);
    check("midrst_row_sel", row_sel, 8'h00);
    check("midrst_col", col_data, 8'h00);
    check("midrst_rom_addr", rom_addr, 6'h00);
    check("midrst_frame_start", frame_start, 1'b0);

    // Release with char_enable still high: restart at row 0, mode back to STOP.
    reset = 1'b1;
    start_address = 3'd6;
    D = 1'b0;
    step(1);
    check("restart_frame_start", frame_start, 1'b1);
    check("restart_addr", rom_addr, 6'h30);
    check("restart_blank", row_sel, 8'h00);
    step(1);
    check("restart_row0_sel", row_sel, 8'h01);
    check("restart_row0_col", col_data, rom_fn(6'h30));
    wait_frame("restart_f1_reached");
    check("restart_f1_addr", rom_addr, 6'h30);
    wait_frame("restart_f2_reached");
    check("restart_f2_addr", rom_addr, 6'h30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/char_scan_ctrl.md
# char_scan_ctrl

Row-scan and scroll sequencer for the 8x8 LED character display, fed by the keyboard decoder's char_enable, start_address_out and S/D/U outputs. It latches the selected glyph, fetches its rows from the synchronous character ROM, and drives one-hot row select plus column data. It applies a periodic vertical scroll (stop/down/up) at frame boundaries only, so a displayed frame never tears.

## Interface
- ROW_HOLD, 50000: drive cycles per row after the one-cycle fetch; minimum 1.
- SCROLL_DIV, 5000000: scroll tick period in clk cycles; minimum 2.
- clk  in  1  system clock, all logic on posedge.
- reset  in  1  synchronous, active-low; sampled on posedge clk.
- char_enable  in  1  display enable from the decoder.
- start_address  in  3  glyph index, 0..6 used.
- S  in  1  scroll stop (level).
- D  in  1  scroll down (level).
- U  in  1  scroll up (level).
- rom_addr  out  6  {glyph[2:0], row[2:0]} to the character ROM.
- rom_data  in  8  ROM output, valid 1 cycle after rom_addr.
- row_sel  out  8  one-hot active-high row drive; 0 = blank.
- col_data  out  8  column pattern for the active row.
- frame_start  out  1  one-cycle pulse at the start of each frame.

## Operation
- Reset (reset=0 at a posedge): state IDLE, row_sel=0, col_data=0, rom_addr=0, frame_start=0, glyph=0, offset=0, mode=STOP, row=0, hold counter=0, tick counter=0, tick_pending=0.
- Mode register: updated every cycle from S/D/U with priority S > D > U. If none is asserted, mode holds.
- Tick counter: free-running, 0..SCROLL_DIV-1. At wrap it sets tick_pending. Further ticks before the pending tick is consumed collapse into one.
- FSM states:
  - IDLE: row_sel=0, col_data=0. When char_enable=1, go to FETCH with row=0 and as a frame boundary.
  - FETCH (1 cycle): rom_addr={glyph, (row+offset) mod 8}, row_sel=0. Next state is DRIVE.
  - DRIVE (ROW_HOLD cycles): on the first DRIVE cycle, col_data<=rom_data and row_sel<=1<<row; both hold for the rest of DRIVE. After the last cycle, row<=row+1 mod 8 and next state is FETCH, or IDLE (see below).
- Frame boundary: the transition into FETCH with row=0. At the boundary, in this order:
  - If char_enable=0, go to IDLE instead of FETCH, with outputs blank from that cycle.
  - glyph<=start_address. If the value differs from the current glyph, offset<=0 and tick_pending is cleared.
  - Otherwise, if tick_pending=1: DOWN gives offset+1 mod 8, UP gives offset-1 mod 8, STOP leaves offset unchanged. tick_pending is cleared in all three modes.
  - frame_start=1 for this FETCH cycle.
- Mid-frame changes to start_address, S/D/U or char_enable have no effect until the next boundary. Mode changes are captured immediately but applied only at the boundary.
- Offset is 3-bit unsigned. Wrap is natural: 7+1=0, 0-1=7.

## Timing
- Row period: ROW_HOLD+1 cycles. Frame period: 8*(ROW_HOLD+1) cycles.
- Latency:
  - char_enable rising in IDLE to first FETCH: 1 cycle.
  - First FETCH to row_sel=0x01: 1 cycle.
- Row 0 of each frame displays ROM row offset, in the sense that the row driven on row_sel bit r is the ROM row (r+offset) mod 8.
- row_sel is 0 during every FETCH cycle. This blanking is intentional, to prevent ghosting.
- A tick landing on a boundary cycle counts as pending for the next boundary, not the current one.
- Reset asserted mid-frame: all outputs are at their reset values on the next cycle, and there is no partial-row completion.

## Test plan
- Reset with ROW_HOLD=3, SCROLL_DIV=40 → all outputs 0. Then char_enable=1, start_address=2 → FETCH with rom_addr=0x10 and frame_start=1; next cycle row_sel=0x01 and col_data=ROM[0x10]; rows advance every 4 cycles through rom_addr 0x11..0x17.
- D held, glyph 2 displayed → at each boundary following a tick, offset increments; after 8 applied ticks, offset wraps 7→0. Row 0 fetch addresses follow 0x10, 0x11, …, 0x17, 0x10.
- U held from offset 0 → next applied tick gives offset=7, with row 0 fetching rom_addr 0x17. S asserted together with D and U → offset frozen across 3 ticks.
- start_address changed 1→4 mid-frame while offset=5 → current frame finishes with glyph 1; next boundary latches glyph 4, offset=0, and first rom_addr=0x20.
- char_enable dropped mid-frame → remaining rows complete. At the boundary, state goes to IDLE, row_sel=0, col_data=0, and no frame_start pulse.
- reset=0 during DRIVE of row 5 → next cycle row_sel=0, col_data=0, rom_addr=0, mode=STOP. With char_enable still 1 after release, the frame restarts at row 0 with glyph=start_address.
